// File: rtl/stream_router_pkg.sv
// Shared helpers for the stream router: level-width arithmetic and the
// legal parameter ranges checked at elaboration.
package stream_router_pkg;

  localparam int unsigned MIN_PORTS      = 2;
  localparam int unsigned MAX_PORTS      = 16;
  localparam int unsigned MIN_FIFO_DEPTH = 2;
  localparam int unsigned MAX_FIFO_DEPTH = 64;

  // Occupancy needs one bit more than the pointers so "full" is representable.
  function automatic int unsigned level_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic bit is_pow2(input int unsigned n);
    return (n != 0) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO; head_data is registered and holds its last
// value while empty.
module sync_fifo
  import stream_router_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH = 32,
  parameter  int unsigned DEPTH      = 4,
  localparam int unsigned PW         = $clog2(DEPTH),
  localparam int unsigned LW         = level_width(DEPTH)
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic                  full,
  output logic                  empty,
  output logic [LW-1:0]         level
);

  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]         level_q, level_d;
  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic                  push_en, pop_en;

  assign full      = (level_q == LW'(DEPTH));
  assign empty     = (level_q == '0);
  assign push_en   = push && !full;
  assign pop_en    = pop && !empty;
  assign head_data = head_q;
  assign level     = level_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_en) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop_en) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({push_en, pop_en})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
    // Head is looked up in the post-update array so a push into an empty
    // FIFO is visible right after the accepting edge.
    head_d = (level_d != '0) ? mem_d[rd_ptr_d] : head_q;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      head_q   <= head_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/stream_router.sv
// 1-to-N registered stream router: steers each input beat into the FIFO of
// its destination port; beats to non-existent ports are dropped and counted.
module stream_router
  import stream_router_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned NUM_PORTS      = 4,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned ADDR_WIDTH     = 4,
  parameter int unsigned DROP_CNT_WIDTH = 16
) (
  input  logic                                         clk,
  input  logic                                         resetn,
  input  logic [DATA_WIDTH-1:0]                        din,
  input  logic [ADDR_WIDTH-1:0]                        din_addr,
  input  logic                                         din_valid,
  output logic                                         din_ready,
  output logic [NUM_PORTS*DATA_WIDTH-1:0]              dout,
  output logic [NUM_PORTS-1:0]                         dout_valid,
  input  logic [NUM_PORTS-1:0]                         dout_ready,
  output logic [DROP_CNT_WIDTH-1:0]                    drop_count,
  output logic [NUM_PORTS*level_width(FIFO_DEPTH)-1:0] fifo_level
);

  localparam int unsigned LW = level_width(FIFO_DEPTH);

  if (!is_pow2(FIFO_DEPTH) || FIFO_DEPTH < MIN_FIFO_DEPTH || FIFO_DEPTH > MAX_FIFO_DEPTH) begin : g_bad_depth
    $error("stream_router: FIFO_DEPTH must be a power of two in 2..64");
  end
  if (NUM_PORTS < MIN_PORTS || NUM_PORTS > MAX_PORTS) begin : g_bad_ports
    $error("stream_router: NUM_PORTS must be in 2..16");
  end
  if (ADDR_WIDTH < $clog2(NUM_PORTS)) begin : g_bad_addr
    $error("stream_router: ADDR_WIDTH too narrow for NUM_PORTS");
  end

  logic [NUM_PORTS-1:0]      full, empty, push, pop;
  logic                      addr_ok, sel_full, accept;
  logic [DROP_CNT_WIDTH-1:0] drop_count_q, drop_count_d;

  assign addr_ok = (32'(din_addr) < NUM_PORTS);

  // din_ready looks only at registered occupancy, never at dout_ready.
  always_comb begin
    sel_full = 1'b0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      if (din_addr == ADDR_WIDTH'(p)) sel_full = full[p];
    end
  end

  assign din_ready = !addr_ok || !sel_full;
  assign accept    = din_valid && din_ready;

  always_comb begin
    push = '0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      push[p] = accept && (din_addr == ADDR_WIDTH'(p));
    end
  end

  assign dout_valid = ~empty;
  assign pop        = dout_valid & dout_ready;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    sync_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
      .clk       (clk),
      .resetn    (resetn),
      .push      (push[p]),
      .push_data (din),
      .pop       (pop[p]),
      .head_data (dout[p*DATA_WIDTH +: DATA_WIDTH]),
      .full      (full[p]),
      .empty     (empty[p]),
      .level     (fifo_level[p*LW +: LW])
    );
  end

  always_comb begin
    drop_count_d = drop_count_q;
    if (accept && !addr_ok && (drop_count_q != '1)) begin
      drop_count_d = drop_count_q + DROP_CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) drop_count_q <= '0;
    else         drop_count_q <= drop_count_d;
  end

  assign drop_count = drop_count_q;

endmodule

// File: tb/tb_stream_router.sv
// Self-checking bench for stream_router: directed scenarios plus random
// traffic compared against per-port queues and a saturating drop tally.
module tb_stream_router;

  localparam int DW = 32;
  localparam int NP = 4;
  localparam int FD = 4;
  localparam int LW = 3;
  localparam int NPB = 3;

  logic clk, resetn;

  logic [DW-1:0]    din_a;
  logic [3:0]       addr_a;
  logic             valid_a, ready_in_a;
  logic [NP*DW-1:0] dout_a;
  logic [NP-1:0]    dvalid_a, dready_a;
  logic [15:0]      drop_a;
  logic [NP*LW-1:0] level_a;

  logic [DW-1:0]     din_b;
  logic [1:0]        addr_b;
  logic              valid_b, ready_in_b;
  logic [NPB*DW-1:0] dout_b;
  logic [NPB-1:0]    dvalid_b, dready_b;
  logic [1:0]        drop_b;
  logic [NPB*LW-1:0] level_b;

  stream_router #(
    .DATA_WIDTH(DW), .NUM_PORTS(NP), .FIFO_DEPTH(FD), .ADDR_WIDTH(4), .DROP_CNT_WIDTH(16)
  ) u_dut_a (
    .clk(clk), .resetn(resetn), .din(din_a), .din_addr(addr_a), .din_valid(valid_a),
    .din_ready(ready_in_a), .dout(dout_a), .dout_valid(dvalid_a), .dout_ready(dready_a),
    .drop_count(drop_a), .fifo_level(level_a)
  );

  stream_router #(
    .DATA_WIDTH(DW), .NUM_PORTS(NPB), .FIFO_DEPTH(FD), .ADDR_WIDTH(2), .DROP_CNT_WIDTH(2)
  ) u_dut_b (
    .clk(clk), .resetn(resetn), .din(din_b), .din_addr(addr_b), .din_valid(valid_b),
    .din_ready(ready_in_b), .dout(dout_b), .dout_valid(dvalid_b), .dout_ready(dready_b),
    .drop_count(drop_b), .fifo_level(level_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] qa [NP][$];
  int            drops_a;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic model_ready(input logic [3:0] a);
    if (int'(a) >= NP) return 1'b1;
    return qa[int'(a)].size() < FD;
  endfunction

  task automatic check_a();
    logic [NP-1:0] ev;
    chk("din_ready", ready_in_a, model_ready(addr_a));
    for (int p = 0; p < NP; p++) begin
      ev[p] = (qa[p].size() != 0);
      chk($sformatf("level[%0d]", p), level_a[p*LW +: LW], qa[p].size());
      if (ev[p]) chk($sformatf("dout[%0d]", p), dout_a[p*DW +: DW], qa[p][0]);
    end
    chk("dout_valid", dvalid_a, ev);
    chk("drop_count", drop_a, drops_a);
  endtask

  task automatic step(input logic v, input logic [3:0] a, input logic [DW-1:0] d,
                      input logic [NP-1:0] rdy);
    logic          acc;
    logic [NP-1:0] popm;
    valid_a = v; addr_a = a; din_a = d; dready_a = rdy;
    #1;
    check_a();
    acc = v && model_ready(a);
    for (int p = 0; p < NP; p++) popm[p] = rdy[p] && (qa[p].size() != 0);
    for (int p = 0; p < NP; p++) if (popm[p]) void'(qa[p].pop_front());
    if (acc) begin
      if (int'(a) < NP) qa[int'(a)].push_back(d);
      else if (drops_a < 65535) drops_a++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    valid_a = 1'b0; addr_a = 4'd1; dready_a = '0;
    valid_b = 1'b0; addr_b = 2'd0; dready_b = '0;
    resetn = 1'b0;
    @(posedge clk);
    #1;
    for (int p = 0; p < NP; p++) qa[p].delete();
    drops_a = 0;
    chk("rst_din_ready", ready_in_a, 1'b1);
    chk("rst_dout_valid", dvalid_a, '0);
    chk("rst_dout", dout_a, '0);
    chk("rst_level", level_a, '0);
    chk("rst_drop", drop_a, '0);
    chk("rst_b_valid", dvalid_b, '0);
    chk("rst_b_drop", drop_b, '0);
    resetn = 1'b1;
  endtask

  initial begin
    resetn = 1'b0;
    valid_a = 1'b0; addr_a = '0; din_a = '0; dready_a = '0;
    valid_b = 1'b0; addr_b = '0; din_b = '0; dready_b = '0;
    drops_a = 0;
    @(posedge clk);
    #1;
    do_reset();

    // Smaller instance: invalid address 3 is dropped, counter saturates at 3.
    for (int i = 0; i < 5; i++) begin
      valid_b = 1'b1; addr_b = 2'd3; din_b = 32'hBAD0_0000 + i;
      #1;
      chk("b_din_ready", ready_in_b, 1'b1);
      @(posedge clk);
      #1;
      chk("b_drop", drop_b, (i + 1 > 3) ? 3 : i + 1);
      chk("b_no_valid", dvalid_b, '0);
    end
    valid_b = 1'b1; addr_b = 2'd2; din_b = 32'h0000_C0DE;
    @(posedge clk);
    #1;
    valid_b = 1'b0;
    chk("b_valid_p2", dvalid_b, 3'b100);
    chk("b_dout_p2", dout_b[2*DW +: DW], 32'h0000_C0DE);
    chk("b_drop_hold", drop_b, 2'd3);
    do_reset();

    // Single beat to port 2, then pop it.
    step(1'b1, 4'd2, 32'hDEADBEEF, 4'b0000);
    step(1'b0, 4'd0, 32'h0, 4'b0100);
    step(1'b0, 4'd0, 32'h0, 4'b0000);

    // Fill port 1, push against full, pop while full, then drain.
    for (int i = 1; i <= 4; i++) step(1'b1, 4'd1, 32'(i), 4'b0000);
    step(1'b1, 4'd1, 32'h5, 4'b0000);
    step(1'b0, 4'd0, 32'h0, 4'b0000);
    step(1'b1, 4'd1, 32'h99, 4'b0010);
    for (int i = 0; i < 4; i++) step(1'b0, 4'd1, 32'h0, 4'b0010);

    // Port 0 held at level 2 under continuous push+pop.
    step(1'b1, 4'd0, 32'h100, 4'b0000);
    step(1'b1, 4'd0, 32'h101, 4'b0000);
    for (int i = 0; i < 10; i++) step(1'b1, 4'd0, 32'h102 + 32'(i), 4'b0001);
    for (int i = 0; i < 3; i++) step(1'b0, 4'd0, 32'h0, 4'b0001);

    // Invalid addresses on the wide instance.
    step(1'b1, 4'd9, 32'h1234, 4'b0000);
    step(1'b1, 4'd15, 32'h5678, 4'b0000);

    // Reset flushes buffered beats; a fresh beat emerges first.
    for (int i = 0; i < 3; i++) step(1'b1, 4'd3, 32'h300 + 32'(i), 4'b0000);
    step(1'b0, 4'd0, 32'h0, 4'b0000);
    do_reset();
    step(1'b1, 4'd3, 32'h333, 4'b0000);
    step(1'b0, 4'd3, 32'h0, 4'b0000);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, 4'($urandom_range(0, 5)), $urandom, 4'($urandom));
    end
    #1;
    check_a();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stream_router.md
# stream_router

Registered 1-to-N stream router with per-output buffering and valid/ready backpressure. Each input beat carries a destination address and is steered into that output's FIFO; each output drains independently under its own consumer's ready. Beats addressed to a non-existent port are dropped and counted. It replaces fixed 4-way combinational steering where downstream consumers can stall.

## Interface
Parameters:
- DATA_WIDTH, 32, payload width in bits (≥1)
- NUM_PORTS, 4, number of output channels (2..16)
- FIFO_DEPTH, 4, entries per output FIFO (power of two, 2..64)
- ADDR_WIDTH, 4, width of din_addr (≥ $clog2(NUM_PORTS))
- DROP_CNT_WIDTH, 16, width of the drop counter

Ports:
- clk  input  1  single clock; all state updates on its rising edge
- resetn  input  1  reset, synchronous and active-low
- din  input  DATA_WIDTH  input payload
- din_addr  input  ADDR_WIDTH  destination port index
- din_valid  input  1  input beat present
- din_ready  output  1  router accepts the beat this cycle
- dout  output  NUM_PORTS*DATA_WIDTH  packed outputs; port p occupies bits [p*DATA_WIDTH +: DATA_WIDTH]
- dout_valid  output  NUM_PORTS  per-port head-of-FIFO valid
- dout_ready  input  NUM_PORTS  per-port consumer ready
- drop_count  output  DROP_CNT_WIDTH  saturating count of dropped beats
- fifo_level  output  NUM_PORTS*($clog2(FIFO_DEPTH)+1)  packed per-port occupancy

## Operation
- Accept: a beat is accepted on a cycle where din_valid && din_ready.
- din_ready is combinational: 1 if din_addr ≥ NUM_PORTS, else !full[din_addr]. It depends only on din_addr and the registered occupancy, never on dout_ready (no full-bypass).
- Valid address: the accepted beat is written to FIFO[din_addr]; other FIFOs are untouched.
- Invalid address (din_addr ≥ NUM_PORTS): the beat is accepted and discarded, and drop_count increments, saturating at all-ones.
- Output p: dout slice p = FIFO[p] head, dout_valid[p] = !empty[p]. Pop occurs when dout_valid[p] && dout_ready[p].
- Per-FIFO push and pop in the same cycle: both occur and the level is unchanged. This is legal only when not full, which the din_ready rule guarantees.
- Pop when empty: no effect. dout slice p holds its last value (don't-care to consumers) while dout_valid[p]=0.
- Ordering: FIFO order per port; no ordering across ports.
- Pointers: $clog2(FIFO_DEPTH) bits, wrap naturally. Occupancy uses one extra bit; full ⇔ level==FIFO_DEPTH, empty ⇔ level==0.
- din_valid=0: din, din_addr ignored; no state change on input side.

## Timing
- Reset (resetn=0 at a clk edge): all levels 0, pointers 0, dout_valid=0, dout=0, drop_count=0, fifo_level=0. din_ready during reset equals the formula (1, since not full). Storage contents are not reset.
- Reset mid-operation flushes all buffered beats; the next edge with resetn=1 starts clean.
- Latency: a beat accepted at edge k is visible on dout/dout_valid after edge k (first cycle following) if its FIFO was empty. Otherwise it appears behind earlier entries.
- Throughput: one input beat per cycle. Each output can sustain one beat per cycle concurrently.
- drop_count and fifo_level update at the same edge as the accept/pop that causes them.

## Structure
- Package stream_router_pkg: function for level width ($clog2(FIFO_DEPTH)+1), localparam helpers, parameter-check assertions (FIFO_DEPTH power of two, ADDR_WIDTH ≥ $clog2(NUM_PORTS)).
- Sub-module sync_fifo (DATA_WIDTH, DEPTH): push/pop/full/empty/level, show-ahead head data. It is instantiated NUM_PORTS times in a generate loop.
- Top contains address decode, din_ready mux, drop counter, and output packing.

## Test plan
- Reset then single beat din=0xDEADBEEF, addr=2, with all dout_ready=0 → after one edge dout_valid=4'b0100, slice 2=0xDEADBEEF, fifo_level[2]=1. Then dout_ready[2]=1 for one cycle → dout_valid=0.
- Fill port 1 with 4 beats (0x1..0x4) with dout_ready=0 → din_ready=0 whenever addr=1, and 1 while addr=0. Drain → order 0x1,0x2,0x3,0x4.
- Full port 1 with dout_ready[1]=1 and din_valid, addr=1 in the same cycle → din_ready=0, beat not taken, level goes 4→3.
- Level 2 on port 0, simultaneous push and pop → level stays 2, order preserved across 10 cycles of continuous traffic.
- Configure NUM_PORTS=3, ADDR_WIDTH=2, send addr=3 five times → din_ready=1, drop_count=5, no dout_valid. With DROP_CNT_WIDTH=2, drop_count saturates at 3.
- Load 3 beats in port 3, assert resetn=0 for one edge → all dout_valid=0, levels 0. Then a new beat to port 3 emerges first.
